// File: rtl/wb_sys_pkg.sv
// Shared Wishbone system definitions.
//   - bridge_state_e : state encoding of the slave-side timeout bridge
//   - TIMEOUT_CNT_W  : width of the saturating timeout event counter
//   - CTI_*          : Wishbone cycle type identifiers shared with the interconnect
package wb_sys_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } bridge_state_e;

  localparam int unsigned TIMEOUT_CNT_W = 16;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter for the bridge's downstream request.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : restart the count at 0 (new request captured)
//   en        : advance the count by one
//   limit     : count value at which the request is considered expired
//   expired   : count has reached limit (never asserted when TIMEOUT is 0)
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (TIMEOUT == 0) begin
      // Timeout disabled: the counter never moves.
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == limit);

endmodule

// File: rtl/wb_slave_timeout_bridge.sv
// Registered bridge between one interconnect slave port and a Wishbone classic slave.
// Each upstream request is captured into registers and replayed downstream; the slave's
// termination and read data come back upstream one cycle later. A slave that stays silent
// for TIMEOUT strobe cycles is terminated with ERR and TIMEOUT_DATA.
// Ports:
//   clk, rstn                          : clock, asynchronous active-low reset
//   ADR/CTI/BTE/DAT_W/SEL/WE/CYC/STB   : upstream request
//   DAT_R/ACK/ERR                      : upstream response (registered)
//   SADR/SCTI/SBTE/SDAT_W/SSEL/SWE     : downstream request (registered)
//   SCYC/SSTB                          : downstream cycle/strobe (registered)
//   SDAT_R/SACK/SERR                   : downstream response
//   timeout                            : one-cycle pulse when a timeout fires
//   timeout_cnt                        : saturating count of timeouts since reset
module wb_slave_timeout_bridge
  import wb_sys_pkg::*;
#(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              TIMEOUT       = 256,
  parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA  = 'hdeadbeef
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       WE,
  input  logic                       CYC,
  input  logic                       STB,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  output logic                       ACK,
  output logic                       ERR,
  output logic [WB_ADDR_WIDTH-1:0]   SADR,
  output logic [2:0]                 SCTI,
  output logic [1:0]                 SBTE,
  output logic [WB_DATA_WIDTH-1:0]   SDAT_W,
  output logic [WB_DATA_WIDTH/8-1:0] SSEL,
  output logic                       SWE,
  output logic                       SCYC,
  output logic                       SSTB,
  input  logic [WB_DATA_WIDTH-1:0]   SDAT_R,
  input  logic                       SACK,
  input  logic                       SERR,
  output logic                       timeout,
  output logic [TIMEOUT_CNT_W-1:0]   timeout_cnt
);

  localparam int unsigned     CntW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  bridge_state_e state_q, state_d;

  logic [WB_ADDR_WIDTH-1:0]   sadr_q, sadr_d;
  logic [2:0]                 scti_q, scti_d;
  logic [1:0]                 sbte_q, sbte_d;
  logic [WB_DATA_WIDTH-1:0]   sdat_w_q, sdat_w_d;
  logic [WB_DATA_WIDTH/8-1:0] ssel_q, ssel_d;
  logic                       swe_q, swe_d;
  logic                       scyc_q, scyc_d;
  logic                       sstb_q, sstb_d;
  logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       timeout_q, timeout_d;
  logic [TIMEOUT_CNT_W-1:0]   tcnt_q, tcnt_d;

  logic capture;
  logic slave_resp;
  logic expired;
  logic cnt_en;

  assign capture    = (state_q == StIdle) && CYC && STB;
  assign slave_resp = SACK || SERR;
  // Count only on cycles where REQ neither terminates nor aborts.
  assign cnt_en     = (state_q == StReq) && !slave_resp && !expired && CYC;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CntW)
  ) u_timeout_counter (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (capture),
    .en      (cnt_en),
    .limit   (Limit),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a slave response outranks the timeout, which outranks an abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (CYC && STB) state_d = StReq;
      StReq: begin
        if (slave_resp || expired) state_d = StResp;
        else if (!CYC)             state_d = StIdle;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    sadr_d    = sadr_q;
    scti_d    = scti_q;
    sbte_d    = sbte_q;
    sdat_w_d  = sdat_w_q;
    ssel_d    = ssel_q;
    swe_d     = swe_q;
    scyc_d    = scyc_q;
    sstb_d    = sstb_q;
    dat_r_d   = dat_r_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    tcnt_d    = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (CYC && STB) begin
          sadr_d   = ADR;
          scti_d   = CTI;
          sbte_d   = BTE;
          sdat_w_d = DAT_W;
          ssel_d   = SEL;
          swe_d    = WE;
          scyc_d   = 1'b1;
          sstb_d   = 1'b1;
        end
      end
      StReq: begin
        if (slave_resp) begin
          dat_r_d = (SACK && swe_q) ? '0 : SDAT_R;
          ack_d   = SACK;
          err_d   = SERR && !SACK;
          scyc_d  = 1'b0;
          sstb_d  = 1'b0;
        end else if (expired) begin
          dat_r_d   = TIMEOUT_DATA;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          if (tcnt_q != '1) tcnt_d = tcnt_q + TIMEOUT_CNT_W'(1);
          scyc_d    = 1'b0;
          sstb_d    = 1'b0;
        end else if (!CYC) begin
          scyc_d = 1'b0;
          sstb_d = 1'b0;
        end
      end
      StResp:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sadr_q    <= '0;
      scti_q    <= '0;
      sbte_q    <= '0;
      sdat_w_q  <= '0;
      ssel_q    <= '0;
      swe_q     <= 1'b0;
      scyc_q    <= 1'b0;
      sstb_q    <= 1'b0;
      dat_r_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      sadr_q    <= sadr_d;
      scti_q    <= scti_d;
      sbte_q    <= sbte_d;
      sdat_w_q  <= sdat_w_d;
      ssel_q    <= ssel_d;
      swe_q     <= swe_d;
      scyc_q    <= scyc_d;
      sstb_q    <= sstb_d;
      dat_r_q   <= dat_r_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign SADR        = sadr_q;
  assign SCTI        = scti_q;
  assign SBTE        = sbte_q;
  assign SDAT_W      = sdat_w_q;
  assign SSEL        = ssel_q;
  assign SWE         = swe_q;
  assign SCYC        = scyc_q;
  assign SSTB        = sstb_q;
  assign DAT_R       = dat_r_q;
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign timeout     = timeout_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_wb_slave_timeout_bridge.sv
// Directed bench for wb_slave_timeout_bridge with TIMEOUT=8. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_wb_slave_timeout_bridge;

  logic        clk;
  logic        rstn;
  logic [31:0] ADR;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic [31:0] DAT_W;
  logic [3:0]  SEL;
  logic        WE;
  logic        CYC;
  logic        STB;
  logic [31:0] DAT_R;
  logic        ACK;
  logic        ERR;
  logic [31:0] SADR;
  logic [2:0]  SCTI;
  logic [1:0]  SBTE;
  logic [31:0] SDAT_W;
  logic [3:0]  SSEL;
  logic        SWE;
  logic        SCYC;
  logic        SSTB;
  logic [31:0] SDAT_R;
  logic        SACK;
  logic        SERR;
  logic        timeout;
  logic [15:0] timeout_cnt;

  int vectors;
  int miscompares;

  wb_slave_timeout_bridge #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .TIMEOUT       (8),
    .TIMEOUT_DATA  (32'hdeadbeef)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ADR         (ADR),
    .CTI         (CTI),
    .BTE         (BTE),
    .DAT_W       (DAT_W),
    .SEL         (SEL),
    .WE          (WE),
    .CYC         (CYC),
    .STB         (STB),
    .DAT_R       (DAT_R),
    .ACK         (ACK),
    .ERR         (ERR),
    .SADR        (SADR),
    .SCTI        (SCTI),
    .SBTE        (SBTE),
    .SDAT_W      (SDAT_W),
    .SSEL        (SSEL),
    .SWE         (SWE),
    .SCYC        (SCYC),
    .SSTB        (SSTB),
    .SDAT_R      (SDAT_R),
    .SACK        (SACK),
    .SERR        (SERR),
    .timeout     (timeout),
    .timeout_cnt (timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    ADR   = a;
    WE    = we;
    DAT_W = d;
    SEL   = 4'hF;
    CTI   = 3'b000;
    BTE   = 2'b00;
    CYC   = 1'b1;
    STB   = 1'b1;
  endtask

  task automatic idle_bus();
    CYC  = 1'b0;
    STB  = 1'b0;
    SACK = 1'b0;
    SERR = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ADR = '0; CTI = '0; BTE = '0; DAT_W = '0; SEL = '0; WE = 1'b0;
    SDAT_R = '0;
    idle_bus();
    #2;
    vectors++;
    if ({DAT_R, ACK, ERR, SADR, SCTI, SBTE, SDAT_W, SSEL, SWE, SCYC, SSTB, timeout,
         timeout_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got SSTB=%b ACK=%b DAT_R=%h tcnt=%0d, want all 0",
               SSTB, ACK, DAT_R, timeout_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    drive_req(32'h100, 1'b1, 32'h12345678);
    CTI = 3'b010;
    BTE = 2'b01;
    @(negedge clk);
    vectors++;
    if ({SCYC, SSTB, ACK, ERR} !== 4'b1100) begin
      miscompares++;
      $display("FAIL write_strobe: got %b want 1100", {SCYC, SSTB, ACK, ERR});
    end
    vectors++;
    if ({SADR, SWE, SDAT_W, SSEL, SCTI, SBTE} !== {32'h100, 1'b1, 32'h12345678, 4'hF, 3'b010, 2'b01})
    begin
      miscompares++;
      $display("FAIL write_request: got SADR=%h SWE=%b SDAT_W=%h SSEL=%h SCTI=%b SBTE=%b",
               SADR, SWE, SDAT_W, SSEL, SCTI, SBTE);
    end
    SACK   = 1'b1;
    SDAT_R = 32'h5555AAAA;
    @(negedge clk);
    vectors++;
    if ({SCYC, SSTB, ACK, ERR, DAT_R} !== {4'b0010, 32'h0}) begin
      miscompares++;
      $display("FAIL write_ack: got %b DAT_R=%h want 0010 DAT_R=0",
               {SCYC, SSTB, ACK, ERR}, DAT_R);
    end
    idle_bus();
    @(negedge clk);
    vectors++;
    if ({ACK, ERR} !== 2'b00) begin
      miscompares++;
      $display("FAIL write_ack_clear: got %b want 00", {ACK, ERR});
    end
  endtask

  task automatic test_read_wait();
    @(negedge clk);
    drive_req(32'h200, 1'b0, 32'h0);
    // three wait states; upstream request wobbles and must be ignored
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      ADR = 32'h999;
      vectors++;
      if ({SSTB, ACK, SADR} !== {1'b1, 1'b0, 32'h200}) begin
        miscompares++;
        $display("FAIL read_wait_%0d: got SSTB=%b ACK=%b SADR=%h want 1 0 200",
                 i, SSTB, ACK, SADR);
      end
    end
    @(negedge clk);
    SACK   = 1'b1;
    SDAT_R = 32'hCAFEF00D;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR, DAT_R} !== {2'b10, 32'hCAFEF00D}) begin
      miscompares++;
      $display("FAIL read_ack: got ACK=%b ERR=%b DAT_R=%h want 1 0 cafef00d", ACK, ERR, DAT_R);
    end
    idle_bus();
    SDAT_R = 32'h0;
    @(negedge clk);
    vectors++;
    if ({ACK, DAT_R} !== {1'b0, 32'hCAFEF00D}) begin
      miscompares++;
      $display("FAIL read_hold: got ACK=%b DAT_R=%h want 0 cafef00d", ACK, DAT_R);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    drive_req(32'h300, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({SSTB, ERR, timeout} !== 3'b100) begin
        miscompares++;
        $display("FAIL timeout_wait_%0d: got SSTB/ERR/timeout=%b want 100",
                 i, {SSTB, ERR, timeout});
      end
    end
    @(negedge clk);
    vectors++;
    if ({SSTB, ACK, ERR, timeout, DAT_R, timeout_cnt} !== {4'b0011, 32'hdeadbeef, 16'd1}) begin
      miscompares++;
      $display("FAIL timeout_fire: got SSTB=%b ACK=%b ERR=%b to=%b DAT_R=%h tcnt=%0d",
               SSTB, ACK, ERR, timeout, DAT_R, timeout_cnt);
    end
    idle_bus();
    @(negedge clk);
    vectors++;
    if ({ERR, timeout, timeout_cnt} !== {2'b00, 16'd1}) begin
      miscompares++;
      $display("FAIL timeout_clear: got ERR=%b to=%b tcnt=%0d want 0 0 1",
               ERR, timeout, timeout_cnt);
    end
  endtask

  task automatic test_ack_at_limit();
    @(negedge clk);
    drive_req(32'h304, 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++) @(negedge clk);
    SACK   = 1'b1;
    SDAT_R = 32'h0BADF00D;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR, timeout, DAT_R, timeout_cnt} !== {3'b100, 32'h0BADF00D, 16'd1}) begin
      miscompares++;
      $display("FAIL ack_at_limit: got ACK=%b ERR=%b to=%b DAT_R=%h tcnt=%0d",
               ACK, ERR, timeout, DAT_R, timeout_cnt);
    end
    idle_bus();
  endtask

  task automatic test_slave_err();
    @(negedge clk);
    drive_req(32'h400, 1'b1, 32'hA5A5A5A5);
    @(negedge clk);
    SERR   = 1'b1;
    SDAT_R = 32'h11112222;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR, timeout, DAT_R} !== {3'b010, 32'h11112222}) begin
      miscompares++;
      $display("FAIL slave_err: got ACK=%b ERR=%b to=%b DAT_R=%h want 0 1 0 11112222",
               ACK, ERR, timeout, DAT_R);
    end
    idle_bus();
    @(negedge clk);
    drive_req(32'h404, 1'b1, 32'h0);
    @(negedge clk);
    SACK   = 1'b1;
    SERR   = 1'b1;
    SDAT_R = 32'h33334444;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR, DAT_R} !== {2'b10, 32'h0}) begin
      miscompares++;
      $display("FAIL ack_wins: got ACK=%b ERR=%b DAT_R=%h want 1 0 0", ACK, ERR, DAT_R);
    end
    idle_bus();
  endtask

  task automatic test_abort();
    @(negedge clk);
    drive_req(32'h500, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    CYC = 1'b0;
    STB = 1'b0;
    @(negedge clk);
    vectors++;
    if ({SCYC, SSTB, ACK, ERR} !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_drop: got %b want 0000", {SCYC, SSTB, ACK, ERR});
    end
    SACK   = 1'b1;
    SDAT_R = 32'h77777777;
    @(negedge clk);
    vectors++;
    if ({SCYC, SSTB, ACK, ERR} !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_late_ack: got %b want 0000", {SCYC, SSTB, ACK, ERR});
    end
    SACK = 1'b0;
    drive_req(32'h508, 1'b1, 32'hFEEDFACE);
    @(negedge clk);
    vectors++;
    if ({SSTB, SADR, SDAT_W} !== {1'b1, 32'h508, 32'hFEEDFACE}) begin
      miscompares++;
      $display("FAIL abort_next_req: got SSTB=%b SADR=%h SDAT_W=%h", SSTB, SADR, SDAT_W);
    end
    SACK = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_next_ack: got %b want 10", {ACK, ERR});
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_req(32'h600, 1'b1, 32'h1);
    @(negedge clk);
    SACK = 1'b1;
    @(negedge clk);
    // master presents the next request while ACK is still high
    SACK = 1'b0;
    drive_req(32'h604, 1'b1, 32'h2);
    @(negedge clk);
    vectors++;
    if ({SSTB, ACK, SADR} !== {2'b00, 32'h600}) begin
      miscompares++;
      $display("FAIL b2b_no_accept_in_resp: got SSTB=%b ACK=%b SADR=%h want 0 0 600",
               SSTB, ACK, SADR);
    end
    @(negedge clk);
    vectors++;
    if ({SSTB, SADR} !== {1'b1, 32'h604}) begin
      miscompares++;
      $display("FAIL b2b_second_capture: got SSTB=%b SADR=%h want 1 604", SSTB, SADR);
    end
    SACK = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_second_ack: got %b want 10", {ACK, ERR});
    end
    idle_bus();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req(32'h700, 1'b1, 32'hABCD0123);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({DAT_R, ACK, ERR, SADR, SCTI, SBTE, SDAT_W, SSEL, SWE, SCYC, SSTB, timeout,
         timeout_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got SSTB=%b SADR=%h DAT_R=%h tcnt=%0d, want all 0",
               SSTB, SADR, DAT_R, timeout_cnt);
    end
    @(negedge clk);
    idle_bus();
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({SCYC, SSTB, ACK, ERR} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_silent: got %b want 0000", {SCYC, SSTB, ACK, ERR});
    end
    drive_req(32'h710, 1'b0, 32'h0);
    @(negedge clk);
    SACK   = 1'b1;
    SDAT_R = 32'h13572468;
    @(negedge clk);
    vectors++;
    if ({ACK, ERR, DAT_R, SADR} !== {2'b10, 32'h13572468, 32'h710}) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got ACK=%b ERR=%b DAT_R=%h SADR=%h",
               ACK, ERR, DAT_R, SADR);
    end
    idle_bus();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_ack_at_limit();
    test_slave_err();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_slave_timeout_bridge.md
Name: wb_slave_timeout_bridge

Overview:
- Registered bridge on one slave-side port of the Wishbone NxN interconnect, between an interconnect slave port and a single Wishbone classic slave.
- Captures each upstream request and replays it to the slave from registers.
- Returns the slave's ACK/ERR and read data upstream one cycle later, registered.
- Terminates with ERR if the slave does not respond within TIMEOUT cycles, so a dead slave cannot hang a master or hold an interconnect arbiter grant.

Parameters:
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width; multiple of 8
- TIMEOUT, 256, cycles of downstream STB without ACK/ERR before timeout; 0 disables the timeout
- TIMEOUT_DATA, 'hdeadbeef, DAT_R value returned on timeout

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- ADR/CTI/BTE/DAT_W/SEL/WE  in  WB_ADDR_WIDTH/3/2/WB_DATA_WIDTH/WB_DATA_WIDTH/8/1  upstream request (from interconnect S* outputs)
- CYC, STB  in  1  upstream cycle/strobe
- DAT_R  out  WB_DATA_WIDTH  upstream read data
- ACK, ERR  out  1  upstream termination
- SADR/SCTI/SBTE/SDAT_W/SSEL/SWE  out  as upstream  downstream request, registered
- SCYC, SSTB  out  1  downstream cycle/strobe
- SDAT_R  in  WB_DATA_WIDTH  downstream read data
- SACK, SERR  in  1  downstream termination
- timeout  out  1  one-cycle pulse when a timeout fires
- timeout_cnt  out  16  saturating count of timeouts since reset

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, counter 0.
  - All outputs 0, including the S* request registers, DAT_R, timeout and timeout_cnt.
  - Reset mid-transaction abandons the transaction silently; no ACK/ERR is issued.
- IDLE, on CYC&&STB:
  - latch ADR, CTI, BTE, DAT_W, SEL, WE into the S* registers;
  - SCYC<=1, SSTB<=1, counter<=0, go REQ.
- REQ, SACK or SERR high (SACK wins if both):
  - DAT_R<=SDAT_R;
  - ACK<=SACK, ERR<=SERR&&!SACK;
  - SCYC<=0, SSTB<=0, go RESP.
- REQ, TIMEOUT!=0, counter==TIMEOUT-1 and no SACK/SERR:
  - ERR<=1, DAT_R<=TIMEOUT_DATA, timeout<=1;
  - timeout_cnt increments, saturating at 16'hFFFF;
  - SCYC/SSTB<=0, go RESP.
  - A slave response in the same cycle as the limit takes priority over the timeout.
- REQ, upstream CYC low (master abort): SCYC/SSTB<=0, go IDLE, no termination issued.
- REQ, otherwise: counter increments.
- RESP: ACK or ERR is high for exactly this one cycle, then cleared. DAT_R holds until the next capture. Go IDLE.
- IDLE does not accept a request in the same cycle it leaves RESP; earliest new capture is the cycle after RESP.
- Latency: from upstream STB sampled to upstream ACK is 2 cycles minimum (slave acking in its first STB cycle); general case is 2 + slave wait states.
- Read data: DAT_R is forced to 0 on write acks. ERR responses keep the captured SDAT_R.
- Ignored inputs:
  - SACK/SERR outside REQ (late or spurious) have no effect.
  - Upstream request changes during REQ are ignored (S* registers hold).
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit. With TIMEOUT=0 the counter is held at 0 and the timeout path is never taken.
- SCTI/SBTE are passed through unchanged. Bursts are executed as individual classic beats.

Decomposition:
- Package wb_sys_pkg holds:
  - the bridge state enum (IDLE, REQ, RESP);
  - localparam TIMEOUT_CNT_W=16;
  - the Wishbone CTI constants shared with the interconnect.
- One sub-module: wb_timeout_counter, with inputs clr, en, limit and output expired. It holds the wait counter, the compare and the TIMEOUT=0 bypass.

Test Plan:
- Write ADR=0x100, DAT_W=0x12345678, SEL=4'hF, slave ACKs in its first STB cycle -> SADR=0x100 and SWE=1 one cycle after capture; upstream ACK 2 cycles after STB; ERR=0.
- Read, slave returns 0xCAFEF00D after 3 wait states -> upstream ACK 5 cycles after STB, DAT_R=0xCAFEF00D, ACK high exactly 1 cycle.
- TIMEOUT=8, slave never responds -> SSTB high 8 cycles then low; ERR=1 for 1 cycle; DAT_R=0xdeadbeef; timeout pulses once; timeout_cnt=1.
- TIMEOUT=8, slave ACKs in the 8th STB cycle -> ACK=1, ERR=0, timeout stays 0, timeout_cnt unchanged.
- Master drops CYC in the 2nd REQ cycle, slave ACKs one cycle later -> SCYC low the next cycle, no upstream ACK/ERR, late SACK ignored, next request captured normally.
- rstn asserted mid-REQ -> all outputs 0 immediately, without waiting for clk; after release the bridge accepts a new request and completes it normally.
